sum_sched: RTL
==============

Name: sum_sched

Overview:
- Round-robin scheduler that shares one sumitup adder between N_REQ requesters.
- Each requester streams a packet of operands.
  - The scheduler buffers the whole packet, then bursts it into the adder.
  - It waits for the adder's done, then presents the sum with the requester ID to the downstream stage.
- Sits between the operand sources and sumitup/downStream in p1_top.

Parameters:
- W, 8, operand and sum width
- N_REQ, 2, number of requesters (2..4)
- MAX_LEN, 8, buffer depth (max operands per packet)
- TIMEOUT, 63, max cycles to wait for adder done

Ports:
- ck  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*W  per-requester operand, requester i at [i*W +: W]
- req_last  in  N_REQ  marks final operand of a packet
- req_ready  out  N_REQ  one-hot; beat accepted when valid&ready
- go_l  out  1  adder go, active-low; adder accumulates in_a on each go_l=0 cycle
- in_a  out  W  operand to adder
- done  in  1  adder done pulse
- sum  in  W  adder result, valid with done
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_sum  out  W  captured sum
- res_id  out  $clog2(N_REQ)  requester that owns res_sum
- res_ovf  out  1  packet exceeded MAX_LEN; extra beats dropped
- res_tmo  out  1  adder timed out; res_sum=0

Behaviour:
- Reset values: go_l=1, in_a=0, req_ready=0, res_valid=0, res_sum=0, res_id=0, res_ovf=0, res_tmo=0, rr pointer=0, state=IDLE. Reset mid-operation aborts the job and discards buffer contents.
- IDLE:
  - Grant the first requester with req_valid=1, searching from rr pointer upward (wrapping).
  - On grant, go to COLLECT next cycle. No grant if no requester is valid.
- COLLECT:
  - req_ready asserted only for the granted requester.
  - Each accepted beat writes buf[cnt] and increments cnt while cnt<MAX_LEN.
  - Beats beyond MAX_LEN are accepted and dropped; ovf is set.
  - On accepted req_last, go to BURST.
  - Non-granted requesters are held off (ready=0) and must keep valid.
- BURST:
  - go_l=0 for exactly cnt consecutive cycles; in_a=buf[0..cnt-1] in order.
  - req_ready=0. Then go to WAIT.
- WAIT:
  - go_l=1, in_a=0. Timeout counter counts from 0.
  - On done: capture sum into res_sum and go to RESULT.
  - If counter reaches TIMEOUT without done: res_sum=0, res_tmo=1, go to RESULT.
  - done and timeout in the same cycle: done wins.
- RESULT:
  - res_valid=1, and res_id/res_ovf/res_tmo are stable until res_valid&res_ready.
  - On handshake: res_valid drops next cycle, rr pointer = granted+1 (mod N_REQ), go to IDLE.
- done outside WAIT is ignored.
- Arithmetic is performed by the adder only; the scheduler passes sum through unchanged (W bits).
- Latency, single-beat packet, no contention: grant 1 cycle, collect 1, burst 1, plus adder latency, plus 1 cycle to res_valid.
- Fairness: a requester waits at most N_REQ-1 jobs.

Decomposition:
- Package sum_sched_pkg:
  - state enum {IDLE, COLLECT, BURST, WAIT, RESULT}
  - W/MAX_LEN defaults
  - counter width localparams
- Sub-module rr_arb (N_REQ): request vector plus pointer in, one-hot grant and index out, purely combinational.
- Operand buffer stays inline.

Test Plan:
- Req0 sends 3,5,7 (last on 7), model adder done 2 cycles after burst -> go_l low exactly 3 cycles with in_a 3,5,7; res_sum=15, res_id=0, ovf=0, tmo=0.
- Req0 and req1 both valid in IDLE, pointer=0 -> req0 served first; after handshake req1 served; next simultaneous request goes to req0.
- Req1 sends 10 beats of value 1 with MAX_LEN=8 -> burst of 8, res_ovf=1, res_sum=8.
- Adder model never asserts done -> res_tmo=1, res_sum=0 exactly TIMEOUT cycles after entering WAIT; the following job completes normally.
- res_ready held low for 5 cycles in RESULT -> res_valid and all result fields stable; no new grant until handshake.
- reset asserted during BURST -> next cycle go_l=1, req_ready=0, res_valid=0; a spurious done afterwards produces no result.

Source files
------------

// File: rtl/sum_sched_pkg.sv
// sum_sched_pkg
//   Shared types and constants for the sum_sched round-robin adder scheduler.
//   - sched_state_e : scheduler FSM states
//   - *_DEF         : default parameter values
//   - cnt_w()       : width of a counter that must hold 0..max_val
package sum_sched_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      BURST   = 3'd2,
      WAIT    = 3'd3,
      RESULT  = 3'd4
   } sched_state_e;

   localparam int W_DEF       = 8;
   localparam int N_REQ_DEF   = 2;
   localparam int MAX_LEN_DEF = 8;
   localparam int TIMEOUT_DEF = 63;

   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Operand count (0..MAX_LEN) and timeout counter (0..TIMEOUT) widths.
   localparam int CNT_W_DEF = cnt_w(MAX_LEN_DEF);
   localparam int TMO_W_DEF = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/sum_sched_if.sv
// sum_sched_if
//   Bundles the requester, adder and result-side signals of sum_sched.
//   Handshake rule for both req_* and res_*: a transfer happens on a rising
//   clock edge where valid and ready are both 1; a source holding valid=1
//   keeps its payload stable until that edge.
//   Modports:
//     master : operand sources, adder and downstream stage (drive requests,
//              done/sum, res_ready)
//     slave  : the scheduler itself
interface sum_sched_if
   import sum_sched_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int N_REQ = N_REQ_DEF
) ();

   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // requester side
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ*W-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   // adder side
   logic               go_l;
   logic [W-1:0]       in_a;
   logic               done;
   logic [W-1:0]       sum;
   // result side
   logic               res_valid;
   logic               res_ready;
   logic [W-1:0]       res_sum;
   logic [ID_W-1:0]    res_id;
   logic               res_ovf;
   logic               res_tmo;

   modport master (
      output req_valid, req_data, req_last, done, sum, res_ready,
      input  req_ready, go_l, in_a, res_valid, res_sum, res_id, res_ovf, res_tmo
   );

   modport slave (
      input  req_valid, req_data, req_last, done, sum, res_ready,
      output req_ready, go_l, in_a, res_valid, res_sum, res_id, res_ovf, res_tmo
   );

endinterface

// File: rtl/sum_sched_rr_arb.sv
// rr_arb
//   Combinational round-robin arbiter. Picks the first asserted request
//   starting at index ptr and moving upward with wrap-around.
//   Ports:
//     req : request vector
//     ptr : highest-priority index this round (0..N_REQ-1)
//     gnt : one-hot grant
//     idx : index of the granted request
//     any : at least one request asserted
module rr_arb
   import sum_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   int cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (int'(ptr) + i) % N_REQ;
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = ID_W'(cand);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sum_sched.sv
// sum_sched
//   Shares one accumulating adder between N_REQ requesters. A granted
//   requester's packet is buffered in full, burst into the adder (go_l low
//   one cycle per operand), and the adder's sum is returned with the
//   requester id. Packets longer than MAX_LEN are truncated (res_ovf); an
//   adder that never answers yields res_sum=0 with res_tmo after TIMEOUT
//   cycles.
//   Ports:
//     ck        : clock
//     reset     : synchronous reset, active-high
//     bus       : sum_sched_if.slave (requests, adder, result)
//     state_dbg : current FSM state
module sum_sched
   import sum_sched_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int N_REQ   = N_REQ_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         ck,
   input  logic         reset,
   sum_sched_if.slave   bus,
   output sched_state_e state_dbg
);

   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = cnt_w(MAX_LEN);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W = cnt_w(TIMEOUT);

   sched_state_e     state_q, state_d;
   logic [ID_W-1:0]  gnt_id_q;
   logic [N_REQ-1:0] gnt_oh_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] idx_q;
   logic [TMO_W-1:0] tmo_q;
   logic             ovf_q;
   logic [W-1:0]     op_buf [MAX_LEN];

   logic             res_valid_q;
   logic [W-1:0]     res_sum_q;
   logic [ID_W-1:0]  res_id_q;
   logic             res_ovf_q;
   logic             res_tmo_q;

   logic [N_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]  arb_idx;
   logic             arb_any;

   logic             beat_valid;
   logic             beat_last;
   logic [W-1:0]     beat_data;
   logic             beat_fire;
   logic             beat_keep;

   rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Select the granted requester's beat.
   always_comb begin
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      beat_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_id_q == ID_W'(i)) begin
            beat_valid = bus.req_valid[i];
            beat_last  = bus.req_last[i];
            beat_data  = bus.req_data[i*W +: W];
         end
      end
   end

   // Ready is always high for the granted requester in COLLECT, so an
   // accepted beat is simply a valid one there.
   assign beat_fire = (state_q == COLLECT) && beat_valid;
   // Beats past MAX_LEN are still accepted, just not stored.
   assign beat_keep = beat_fire && (cnt_q < CNT_W'(MAX_LEN));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (arb_any) state_d = COLLECT;
         COLLECT: if (beat_fire && beat_last) state_d = BURST;
         BURST:   if (idx_q == cnt_q - CNT_W'(1)) state_d = WAIT;
         // done has priority; it is checked in the same branch as timeout.
         WAIT:    if (bus.done || (tmo_q == TMO_W'(TIMEOUT - 1))) state_d = RESULT;
         RESULT:  if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ck) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_id_q    <= '0;
         gnt_oh_q    <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_id_q    <= '0;
         res_ovf_q   <= 1'b0;
         res_tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (arb_any) begin
                  gnt_id_q <= arb_idx;
                  gnt_oh_q <= arb_gnt;
                  cnt_q    <= '0;
                  ovf_q    <= 1'b0;
               end
            end
            COLLECT: begin
               idx_q <= '0;
               if (beat_keep)      cnt_q <= cnt_q + CNT_W'(1);
               else if (beat_fire) ovf_q <= 1'b1;
            end
            BURST: begin
               idx_q <= idx_q + CNT_W'(1);
               tmo_q <= '0;
            end
            WAIT: begin
               if (state_d == RESULT) begin
                  res_valid_q <= 1'b1;
                  res_id_q    <= gnt_id_q;
                  res_ovf_q   <= ovf_q;
                  res_sum_q   <= bus.done ? bus.sum : '0;
                  res_tmo_q   <= !bus.done;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            RESULT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  rr_ptr_q    <= (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Buffer storage needs no reset: cnt_q alone decides what is valid.
   always_ff @(posedge ck) begin
      if (!reset && beat_keep) op_buf[cnt_q[IDX_W-1:0]] <= beat_data;
   end

   assign bus.req_ready = (state_q == COLLECT) ? gnt_oh_q : '0;
   assign bus.go_l      = (state_q != BURST);
   assign bus.in_a      = (state_q == BURST) ? op_buf[idx_q[IDX_W-1:0]] : '0;
   assign bus.res_valid = res_valid_q;
   assign bus.res_sum   = res_sum_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_ovf   = res_ovf_q;
   assign bus.res_tmo   = res_tmo_q;
   assign state_dbg     = state_q;

endmodule
